// File: rtl/eth_f_stat_pkg.sv
// Shared types for the packet-statistics accumulator: snapshot bundle, clear FSM
// states and the mod-256 delta helper.
package eth_f_stat_pkg;

  localparam int unsigned SNAP_PERIOD = 16;

  typedef struct packed {
    logic [7:0] sop;
    logic [7:0] eop;
    logic [7:0] err;
  } stat_snap_t;

  typedef enum logic [1:0] {
    IDLE,
    CLR_ASSERT,
    CLR_WAIT
  } clr_state_e;

  // Upstream advances by fewer than 256 per window, so the wrapped difference is exact.
  function automatic logic [7:0] delta8(input logic [7:0] cur, input logic [7:0] prev);
    return cur - prev;
  endfunction

endpackage

// File: rtl/eth_f_pkt_stat_accum_if.sv
// Snapshot inputs from the stat counter plus the CSR-side clear/snapshot handshake.
interface eth_f_pkt_stat_accum_if #(
  parameter int unsigned CNT_W = 64
);
  logic             stat_cnt_vld;
  logic [7:0]       stat_sop_cnt;
  logic [7:0]       stat_eop_cnt;
  logic [7:0]       stat_err_cnt;
  logic             stat_cnt_clr;
  logic             csr_clr_req;
  logic             csr_clr_ack;
  logic             csr_snap_req;
  logic             csr_snap_ack;
  logic [CNT_W-1:0] csr_sop_total;
  logic [CNT_W-1:0] csr_eop_total;
  logic [CNT_W-1:0] csr_err_total;
  logic             csr_stale;

  modport master (
    output stat_cnt_vld, stat_sop_cnt, stat_eop_cnt, stat_err_cnt,
    output csr_clr_req, csr_snap_req,
    input  stat_cnt_clr, csr_clr_ack, csr_snap_ack,
    input  csr_sop_total, csr_eop_total, csr_err_total, csr_stale
  );

  modport slave (
    input  stat_cnt_vld, stat_sop_cnt, stat_eop_cnt, stat_err_cnt,
    input  csr_clr_req, csr_snap_req,
    output stat_cnt_clr, csr_clr_ack, csr_snap_ack,
    output csr_sop_total, csr_eop_total, csr_err_total, csr_stale
  );
endinterface

// File: rtl/eth_f_stat_delta_acc.sv
// One counter lane: remembers the previous 8-bit snapshot and folds the wrapped
// delta into a CNT_W running total.
module eth_f_stat_delta_acc
  import eth_f_stat_pkg::*;
#(
  parameter int unsigned CNT_W = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             upd,
  input  logic             zero,
  input  logic [7:0]       cnt_i,
  output logic [CNT_W-1:0] tot_o
);

  logic [7:0]       prev_q, prev_d;
  logic [CNT_W-1:0] tot_q, tot_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    prev_d = prev_q;
    tot_d  = tot_q;
    if (zero) begin
      prev_d = '0;
      tot_d  = '0;
    end else if (upd) begin
      prev_d = cnt_i;
      tot_d  = tot_q + CNT_W'(delta8(cnt_i, prev_q));
    end
  end

  // NOTE: state registers use <= so all flops sample pre-edge values, whatever the order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prev_q <= '0;
      tot_q  <= '0;
    end else begin
      prev_q <= prev_d;
      tot_q  <= tot_d;
    end
  end

  assign tot_o = tot_q;

endmodule

// File: rtl/eth_f_pkt_stat_accum.sv
// Accumulates wrapping SOP/EOP/ERR snapshots into wide totals, with an atomic CSR
// shadow, a staleness flag and a request/ack clear sequencer for the stat counter.
module eth_f_pkt_stat_accum
  import eth_f_stat_pkg::*;
#(
  parameter int unsigned CNT_W     = 64,
  parameter int unsigned CLR_HOLD  = 4,
  parameter int unsigned STALE_CYC = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  eth_f_pkt_stat_accum_if.slave  bus
);

  // A stale limit under two snapshot periods would flag a healthy counter.
  localparam int unsigned STALE_MIN = 2 * SNAP_PERIOD;
  localparam int unsigned STALE_LIM = (STALE_CYC < STALE_MIN) ? STALE_MIN : STALE_CYC;
  localparam int unsigned TMR_W     = $clog2(STALE_LIM + 1);
  localparam logic [3:0]  HOLD_INIT = 4'(CLR_HOLD - 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(STALE_LIM);

  stat_snap_t       snap;
  clr_state_e       state_q, state_d;
  logic [3:0]       hold_q, hold_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             vld_d_q;
  logic             upd;
  logic             clr_done;
  logic             snap_ack_q;
  logic             clr_ack_q;
  logic [CNT_W-1:0] tot_sop, tot_eop, tot_err;
  logic [CNT_W-1:0] sh_sop_q, sh_eop_q, sh_err_q;
  logic [CNT_W-1:0] sh_sop_d, sh_eop_d, sh_err_d;

  assign snap = '{sop: bus.stat_sop_cnt, eop: bus.stat_eop_cnt, err: bus.stat_err_cnt};
  assign upd  = bus.stat_cnt_vld & ~vld_d_q & (state_q == IDLE);

  eth_f_stat_delta_acc #(.CNT_W(CNT_W)) u_acc_sop (
    .i_clk(i_clk), .i_rst(i_rst), .upd(upd), .zero(clr_done), .cnt_i(snap.sop), .tot_o(tot_sop)
  );
  eth_f_stat_delta_acc #(.CNT_W(CNT_W)) u_acc_eop (
    .i_clk(i_clk), .i_rst(i_rst), .upd(upd), .zero(clr_done), .cnt_i(snap.eop), .tot_o(tot_eop)
  );
  eth_f_stat_delta_acc #(.CNT_W(CNT_W)) u_acc_err (
    .i_clk(i_clk), .i_rst(i_rst), .upd(upd), .zero(clr_done), .cnt_i(snap.err), .tot_o(tot_err)
  );

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    clr_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.csr_clr_req) begin
          state_d = CLR_ASSERT;
          hold_d  = HOLD_INIT;
        end
      end
      CLR_ASSERT: begin
        if (hold_q == '0) state_d = CLR_WAIT;
        else              hold_d  = hold_q - 4'd1;
      end
      CLR_WAIT: begin
        // The counter must have left its valid phase before totals restart from zero.
        if (!bus.stat_cnt_vld) begin
          clr_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    timer_d = timer_q;
    if (upd || clr_done)      timer_d = '0;
    else if (timer_q != TMR_MAX) timer_d = timer_q + 1'b1;
  end

  // A snapshot taken in the completing clear cycle still returns pre-clear totals.
  always_comb begin
    sh_sop_d = sh_sop_q;
    sh_eop_d = sh_eop_q;
    sh_err_d = sh_err_q;
    if (bus.csr_snap_req) begin
      sh_sop_d = tot_sop;
      sh_eop_d = tot_eop;
      sh_err_d = tot_err;
    end else if (clr_done) begin
      sh_sop_d = '0;
      sh_eop_d = '0;
      sh_err_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      timer_q    <= '0;
      vld_d_q    <= 1'b0;
      snap_ack_q <= 1'b0;
      clr_ack_q  <= 1'b0;
      sh_sop_q   <= '0;
      sh_eop_q   <= '0;
      sh_err_q   <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      timer_q    <= timer_d;
      vld_d_q    <= bus.stat_cnt_vld;
      snap_ack_q <= bus.csr_snap_req;
      clr_ack_q  <= clr_done;
      sh_sop_q   <= sh_sop_d;
      sh_eop_q   <= sh_eop_d;
      sh_err_q   <= sh_err_d;
    end
  end

  assign bus.stat_cnt_clr  = (state_q == CLR_ASSERT);
  assign bus.csr_clr_ack   = clr_ack_q;
  assign bus.csr_snap_ack  = snap_ack_q;
  assign bus.csr_sop_total = sh_sop_q;
  assign bus.csr_eop_total = sh_eop_q;
  assign bus.csr_err_total = sh_err_q;
  assign bus.csr_stale     = (timer_q == TMR_MAX);

endmodule

// File: tb/tb_eth_f_pkt_stat_accum.sv
// Self-checking bench: reset/stale/clear corner sequences, a table of snapshot
// vectors, and randomized windows checked against an increment-summing model.
module tb_eth_f_pkt_stat_accum;
  import eth_f_stat_pkg::*;

  localparam int unsigned CNT_W     = 64;
  localparam int unsigned CLR_HOLD  = 4;
  localparam int unsigned STALE_CYC = 64;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  eth_f_pkt_stat_accum_if #(.CNT_W(CNT_W)) bus ();

  eth_f_pkt_stat_accum #(
    .CNT_W(CNT_W), .CLR_HOLD(CLR_HOLD), .STALE_CYC(STALE_CYC)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [7:0]  sop, eop, err;
    logic [63:0] exp_sop, exp_eop, exp_err;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst             = 1'b1;
    bus.stat_cnt_vld  = 1'b0;
    bus.stat_sop_cnt  = '0;
    bus.stat_eop_cnt  = '0;
    bus.stat_err_cnt  = '0;
    bus.csr_clr_req   = 1'b0;
    bus.csr_snap_req  = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  task automatic apply_window(input logic [7:0] s, input logic [7:0] e, input logic [7:0] r);
    bus.stat_cnt_vld = 1'b0;
    bus.stat_sop_cnt = s;
    bus.stat_eop_cnt = e;
    bus.stat_err_cnt = r;
    repeat (4) step();
    bus.stat_cnt_vld = 1'b1;
    repeat (4) step();
    bus.stat_cnt_vld = 1'b0;
  endtask

  task automatic snap_check(input string tag, input logic [63:0] es,
                            input logic [63:0] ee, input logic [63:0] er);
    bus.csr_snap_req = 1'b1;
    step();
    bus.csr_snap_req = 1'b0;
    check({tag, "_ack"}, 64'(bus.csr_snap_ack), 64'd1);
    check({tag, "_sop"}, bus.csr_sop_total, es);
    check({tag, "_eop"}, bus.csr_eop_total, ee);
    check({tag, "_err"}, bus.csr_err_total, er);
  endtask

  task automatic wait_clr_ack(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (bus.csr_clr_ack) seen = 1'b1;
    end
    check({tag, "_ack_seen"}, 64'(seen), 64'd1);
  endtask

  initial begin
    vecs[0] = '{8'h10, 8'h08, 8'h00, 64'h10,  64'h08,  64'h00};
    vecs[1] = '{8'h25, 8'h20, 8'h01, 64'h25,  64'h20,  64'h01};
    vecs[2] = '{8'h40, 8'h30, 8'h01, 64'h40,  64'h30,  64'h01};
    vecs[3] = '{8'hF0, 8'hA0, 8'h80, 64'hF0,  64'hA0,  64'h80};
    vecs[4] = '{8'h05, 8'h10, 8'h02, 64'h105, 64'h110, 64'h102};
    vecs[5] = '{8'h05, 8'h10, 8'h02, 64'h105, 64'h110, 64'h102};
    vecs[6] = '{8'hFF, 8'h0F, 8'h01, 64'h1FF, 64'h20F, 64'h201};

    // Reset state
    do_reset();
    check("rst_clr",      64'(bus.stat_cnt_clr), 64'd0);
    check("rst_clr_ack",  64'(bus.csr_clr_ack),  64'd0);
    check("rst_snap_ack", 64'(bus.csr_snap_ack), 64'd0);
    check("rst_stale",    64'(bus.csr_stale),    64'd0);
    check("rst_sop",      bus.csr_sop_total,     64'd0);

    // Stale flag rises exactly on the STALE_CYC-th cycle without an edge
    for (int i = 1; i <= 70; i++) begin
      step();
      check($sformatf("stale_c%0d", i), 64'(bus.csr_stale), 64'(i >= int'(STALE_CYC)));
    end
    bus.stat_cnt_vld = 1'b1;
    step();
    check("stale_cleared", 64'(bus.csr_stale), 64'd0);
    bus.stat_cnt_vld = 1'b0;
    step();

    // Table-driven snapshot sequence, including the 0xF0 -> 0x05 wrap
    foreach (vecs[i]) begin
      apply_window(vecs[i].sop, vecs[i].eop, vecs[i].err);
      snap_check($sformatf("vec%0d", i), vecs[i].exp_sop, vecs[i].exp_eop, vecs[i].exp_err);
    end

    // Clear: stat_cnt_clr held CLR_HOLD cycles, ack only once vld drops
    begin
      int n_clr = 0;
      int n_ack = 0;
      bus.csr_clr_req = 1'b1;
      step();
      bus.csr_clr_req  = 1'b0;
      bus.stat_cnt_vld = 1'b1;
      bus.stat_sop_cnt = 8'h77;
      for (int i = 0; i < 12; i++) begin
        if (bus.stat_cnt_clr) n_clr++;
        if (bus.csr_clr_ack)  n_ack++;
        step();
      end
      check("clr_hold_len", 64'(n_clr), 64'(CLR_HOLD));
      check("clr_no_early_ack", 64'(n_ack), 64'd0);
      bus.stat_cnt_vld = 1'b0;
      step();
      check("clr_ack_pulse", 64'(bus.csr_clr_ack), 64'd1);
      check("clr_low_at_ack", 64'(bus.stat_cnt_clr), 64'd0);
      step();
      check("clr_ack_single", 64'(bus.csr_clr_ack), 64'd0);
      snap_check("post_clr", 64'd0, 64'd0, 64'd0);
    end

    // Snap in the same cycle as an update sees the pre-update totals
    bus.stat_sop_cnt = 8'h30;
    bus.stat_eop_cnt = 8'h11;
    bus.stat_err_cnt = 8'h22;
    bus.stat_cnt_vld = 1'b1;
    snap_check("snap_same_upd", 64'd0, 64'd0, 64'd0);
    snap_check("snap_after_upd", 64'h30, 64'h11, 64'h22);

    // Update and clear request together: update lands, snap mid-clear returns it
    bus.stat_cnt_vld = 1'b0;
    step();
    bus.stat_sop_cnt = 8'h50;
    bus.stat_cnt_vld = 1'b1;
    bus.csr_clr_req  = 1'b1;
    step();
    bus.csr_clr_req = 1'b0;
    check("sim_clr_started", 64'(bus.stat_cnt_clr), 64'd1);
    snap_check("snap_in_clr", 64'h50, 64'h11, 64'h22);
    bus.stat_cnt_vld = 1'b0;
    wait_clr_ack("sim_clr", 30);
    step();
    snap_check("sim_post_clr", 64'd0, 64'd0, 64'd0);

    // Reset in the middle of CLR_ASSERT aborts the clear silently
    apply_window(8'h12, 8'h34, 8'h56);
    snap_check("pre_abort", 64'h12, 64'h34, 64'h56);
    bus.csr_clr_req = 1'b1;
    step();
    bus.csr_clr_req = 1'b0;
    step();
    check("abort_clr_on", 64'(bus.stat_cnt_clr), 64'd1);
    i_rst = 1'b1;
    #1;
    check("abort_clr_off", 64'(bus.stat_cnt_clr), 64'd0);
    check("abort_ack",     64'(bus.csr_clr_ack),  64'd0);
    check("abort_sop",     bus.csr_sop_total,     64'd0);
    check("abort_err",     bus.csr_err_total,     64'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    begin
      int n_clr = 0;
      int n_ack = 0;
      for (int i = 0; i < 10; i++) begin
        step();
        if (bus.stat_cnt_clr) n_clr++;
        if (bus.csr_clr_ack)  n_ack++;
      end
      check("abort_idle_clr", 64'(n_clr), 64'd0);
      check("abort_idle_ack", 64'(n_ack), 64'd0);
    end

    // Randomized windows against a model that sums the true per-window increments
    do_reset();
    begin
      logic [7:0]  cs = '0, ce = '0, cr = '0;
      logic [63:0] ms = '0, me = '0, mr = '0;
      logic [63:0] ps = '0, pe = '0, pr = '0;
      logic [63:0] xs, xe, xr;
      bit          snap;
      for (int w = 0; w < 40; w++) begin
        for (int c = 0; c < int'(SNAP_PERIOD); c++) begin
          if (c == 0) begin
            ps = 64'($urandom_range(0, 255));
            pe = 64'($urandom_range(0, 255));
            pr = 64'($urandom_range(0, 255));
            cs = cs + ps[7:0];
            ce = ce + pe[7:0];
            cr = cr + pr[7:0];
          end
          bus.stat_sop_cnt = cs;
          bus.stat_eop_cnt = ce;
          bus.stat_err_cnt = cr;
          bus.stat_cnt_vld = (c >= int'(SNAP_PERIOD) / 2);
          snap = ($urandom_range(0, 5) == 0);
          bus.csr_snap_req = snap;
          xs = ms; xe = me; xr = mr;
          if (c == int'(SNAP_PERIOD) / 2) begin
            ms = ms + ps;
            me = me + pe;
            mr = mr + pr;
          end
          step();
          bus.csr_snap_req = 1'b0;
          if (snap) begin
            check($sformatf("rnd_w%0d_c%0d_ack", w, c), 64'(bus.csr_snap_ack), 64'd1);
            check($sformatf("rnd_w%0d_c%0d_sop", w, c), bus.csr_sop_total, xs);
            check($sformatf("rnd_w%0d_c%0d_eop", w, c), bus.csr_eop_total, xe);
            check($sformatf("rnd_w%0d_c%0d_err", w, c), bus.csr_err_total, xr);
          end
          if (c == 0 && w > 0)
            check($sformatf("rnd_w%0d_stale", w), 64'(bus.csr_stale), 64'd0);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
